// File: rtl/serial_adder_subtractor.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB first.
// start/busy/done handshake with carry, signed overflow, zero and optional saturation.
module serial_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ctrl_q, ctrl_d;
  logic             sat_q, sat_d;
  logic             amsb_q, amsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   ext;
  logic             cin_msb;
  logic             ovf_w;
  logic [WIDTH-1:0] res;

  // Operands shift right each slice, so the active slice is always bits [DIGIT-1:0].
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    sat_d   = sat_q;
    amsb_d  = amsb_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    bx  = b_q[DIGIT-1:0] ^ {DIGIT{ctrl_q}};
    ext = {1'b0, a_q[DIGIT-1:0]} + {1'b0, bx}
        + {{DIGIT{1'b0}}, cy_q};
    // Carry into the slice MSB recovered from its sum bit.
    cin_msb = ext[DIGIT-1] ^ a_q[DIGIT-1] ^ bx[DIGIT-1];
    ovf_w   = cin_msb ^ ext[DIGIT];
    res     = WIDTH'({ext[DIGIT-1:0], sum_q} >> DIGIT);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ctrl_d  = ctrl;
          sat_d   = sat;
          amsb_d  = a[WIDTH-1];
          cy_d    = ctrl;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = ext[DIGIT];
        sum_d = res;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          carry_d = ext[DIGIT];
          ovf_d   = ovf_w;
          if (sat_q && ovf_w) begin
            sum_d = amsb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
          end
          zero_d = (sum_d == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 1'b0;
      sat_q   <= 1'b0;
      amsb_q  <= 1'b0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      sat_q   <= sat_d;
      amsb_q  <= amsb_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor: three DIGIT configurations of a 16-bit unit
// checked against an arithmetic reference model on every done pulse.
module tb_serial_adder_subtractor;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i [3];
  logic [15:0] a_i     [3];
  logic [15:0] b_i     [3];
  logic        ctrl_i  [3];
  logic        sat_i   [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic [15:0] sum_o   [3];
  logic        carry_o [3];
  logic        ovf_o   [3];
  logic        zero_o  [3];

  int   nl [3]        = '{4, 1, 16};
  int   ndone [3]     = '{0, 0, 0};
  int   last_done [3] = '{0, 0, 0};
  int   prev_done [3] = '{0, 0, 0};
  exp_t q [3][$];
  int   cyc   = 0;
  int   ncmp  = 0;
  int   nfail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 16 : 1;
    serial_adder_subtractor #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_i[g]),
      .a       (a_i[g]),
      .b       (b_i[g]),
      .ctrl    (ctrl_i[g]),
      .sat     (sat_i[g]),
      .busy    (busy_o[g]),
      .done    (done_o[g]),
      .sum     (sum_o[g]),
      .carry   (carry_o[g]),
      .overflow(ovf_o[g]),
      .zero    (zero_o[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv);
    exp_t        m;
    logic [16:0] r;
    logic [15:0] bb;
    bb  = cv ? ~bv : bv;
    r   = {1'b0, av} + {1'b0, bb} + 17'(cv);
    m.c = r[16];
    m.s = r[15:0];
    if (cv) m.v = (av[15] != bv[15]) && (m.s[15] != av[15]);
    else    m.v = (av[15] == bv[15]) && (m.s[15] != av[15]);
    if (sv && m.v) m.s = av[15] ? 16'h8000 : 16'h7fff;
    m.z   = (m.s == 16'h0000);
    m.due = 0;
    return m;
  endfunction

  // Single compare process for all instances.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (done_o[i]) begin
        ndone[i]++;
        prev_done[i] = last_done[i];
        last_done[i] = cyc;
        chk($sformatf("u%0d_done_pending", i), 32'(q[i].size() != 0), 1);
        if (q[i].size() != 0) begin
          e = q[i].pop_front();
          chk($sformatf("u%0d_sum", i), sum_o[i], e.s);
          chk($sformatf("u%0d_carry", i), carry_o[i], e.c);
          chk($sformatf("u%0d_overflow", i), ovf_o[i], e.v);
          chk($sformatf("u%0d_zero", i), zero_o[i], e.z);
          chk($sformatf("u%0d_done_cycle", i), cyc, e.due);
          chk($sformatf("u%0d_busy_at_done", i), busy_o[i], 0);
        end
      end else if (q[i].size() != 0 && cyc > q[i][0].due) begin
        chk($sformatf("u%0d_done_missing", i), cyc, q[i][0].due);
        void'(q[i].pop_front());
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] av,
                       input logic [15:0] bv, input logic cv, input logic sv,
                       input logic [15:0] es, input logic ec,
                       input logic ev, input logic ez, input logic lit);
    exp_t m;
    int   t = 0;
    @(negedge clk);
    while (busy_o[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy_o[i]) chk("issue_idle_timeout", busy_o[i], 0);
    a_i[i]     = av;
    b_i[i]     = bv;
    ctrl_i[i]  = cv;
    sat_i[i]   = sv;
    start_i[i] = 1'b1;
    m = model(av, bv, cv, sv);
    if (lit) begin
      chk("model_sum", m.s, es);
      if (ec !== 1'bx) chk("model_carry", m.c, ec);
      if (ev !== 1'bx) chk("model_overflow", m.v, ev);
      if (ez !== 1'bx) chk("model_zero", m.z, ez);
    end
    @(posedge clk);
    #1;
    start_i[i] = 1'b0;
    m.due = cyc + nl[i];
    q[i].push_back(m);
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while ((q[i].size() != 0 || busy_o[i]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q[i].size() != 0) chk("drain_timeout", q[i].size(), 0);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_busy", nm, i), busy_o[i], 0);
      chk($sformatf("%s_u%0d_done", nm, i), done_o[i], 0);
      chk($sformatf("%s_u%0d_sum", nm, i), sum_o[i], 0);
      chk($sformatf("%s_u%0d_carry", nm, i), carry_o[i], 0);
      chk($sformatf("%s_u%0d_ovf", nm, i), ovf_o[i], 0);
      chk($sformatf("%s_u%0d_zero", nm, i), zero_o[i], 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] edge_v [6];
    logic [15:0] ra, rb;
    int          n;
    edge_v = '{16'h0000, 16'hffff, 16'h7fff, 16'h8000, 16'h0001, 16'h8001};
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      a_i[i]     = '0;
      b_i[i]     = '0;
      ctrl_i[i]  = 1'b0;
      sat_i[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Basic add and latency
    issue(0, 16'h0001, 16'h0000, 0, 0, 16'h0001, 0, 0, 0, 1);
    wait_idle(0);

    // Back-to-back subtracts, second start in the done cycle
    issue(0, 16'h0005, 16'h0003, 1, 0, 16'h0002, 1, 0, 0, 1);
    issue(0, 16'h0002, 16'h0004, 1, 0, 16'hfffe, 0, 0, 0, 1);
    wait_idle(0);
    chk("b2b_gap", last_done[0] - prev_done[0], 5);

    // Overflow and saturation
    issue(0, 16'h7fff, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, 1);
    issue(0, 16'h7fff, 16'h0001, 0, 1, 16'h7fff, 0, 1, 0, 1);
    issue(0, 16'h8000, 16'h0001, 1, 1, 16'h8000, 1, 1, 0, 1);
    issue(0, 16'hffff, 16'h0001, 0, 0, 16'h0000, 1, 0, 1, 1);
    issue(0, 16'h000b, 16'h0006, 1, 0, 16'h0005, 1, 0, 0, 1);
    wait_idle(0);

    // start while busy is ignored
    n = ndone[0];
    issue(0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 0, 1);
    @(negedge clk);
    a_i[0]     = 16'hffff;
    b_i[0]     = 16'hffff;
    ctrl_i[0]  = 1'b1;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("busy_start_one_done", ndone[0] - n, 1);

    // Reset mid-operation
    n = ndone[0];
    issue(0, 16'h00ff, 16'h0001, 0, 0, 16'h0100, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    q[0].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", ndone[0] - n, 0);
    issue(0, 16'h00ff, 16'h0001, 0, 0, 16'h0100, 0, 0, 0, 1);
    wait_idle(0);
    chk("after_rst_done", ndone[0] - n, 1);

    // Latency of the other configurations
    for (int k = 1; k < 3; k++) begin
      issue(k, 16'h7fff, 16'h0001, 0, 1, 16'h7fff, 0, 1, 0, 1);
      issue(k, 16'h000b, 16'h0006, 1, 0, 16'h0005, 1, 0, 0, 1);
      wait_idle(k);
    end

    // Random sweep
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < ((k == 0) ? 300 : 1000); j++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if ($urandom_range(0, 3) == 0) ra = edge_v[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) rb = edge_v[$urandom_range(0, 5)];
        issue(k, ra, rb, 1'($urandom), 1'($urandom), '0, 0, 0, 0, 0);
      end
      wait_idle(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
